// File: rtl/alu_pkg.sv
// Shared ALU definitions: op one-hot bit positions and default datapath widths.
package alu_pkg;

    localparam int unsigned ALU_OPW  = 12;
    localparam int unsigned DW       = 16;
    localparam int unsigned IMMW     = 5;
    localparam int unsigned TAGW_DEF = 3;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_MUL = 2;
    localparam int unsigned OP_DIV = 3;
    localparam int unsigned OP_MOD = 4;
    localparam int unsigned OP_CMP = 5;
    localparam int unsigned OP_AND = 6;
    localparam int unsigned OP_OR  = 7;
    localparam int unsigned OP_NOT = 8;
    localparam int unsigned OP_MOV = 9;
    localparam int unsigned OP_LSL = 10;
    localparam int unsigned OP_LSR = 11;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: the lowest set request bit wins, reported one-hot and as an index.
module rs_select #(
    parameter int unsigned N = 4
)(
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                gnt[i] = 1'b1;
                idx    = ($clog2(N))'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Age-ordered, compacting ALU reservation station; issues the oldest ready op per cycle.
module alu_rs
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = TAGW_DEF,
    parameter int unsigned DW    = alu_pkg::DW
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [ALU_OPW-1:0]           disp_alusignals,
    input  logic                         disp_isimmediate,
    input  logic [IMMW-1:0]              disp_immx,
    input  logic                         disp_src1_rdy,
    input  logic                         disp_src2_rdy,
    input  logic [TAGW-1:0]              disp_src1_tag,
    input  logic [TAGW-1:0]              disp_src2_tag,
    input  logic [DW-1:0]                disp_src1_val,
    input  logic [DW-1:0]                disp_src2_val,
    input  logic [TAGW-1:0]              disp_dst_tag,
    input  logic                         cdb_valid,
    input  logic [TAGW-1:0]              cdb_tag,
    input  logic [DW-1:0]                cdb_val,
    output logic                         iss_valid,
    output logic [ALU_OPW-1:0]           iss_alusignals,
    output logic [DW-1:0]                iss_op1,
    output logic [DW-1:0]                iss_op2,
    output logic [IMMW-1:0]              iss_immx,
    output logic                         iss_isimmediate,
    output logic [TAGW-1:0]              iss_dst_tag,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCCW = $clog2(DEPTH + 1);
    localparam int unsigned IW   = $clog2(DEPTH);

    typedef struct packed {
        logic [ALU_OPW-1:0] alu;
        logic               isimm;
        logic [IMMW-1:0]    immx;
        logic [TAGW-1:0]    dst;
        logic               r1;
        logic [TAGW-1:0]    t1;
        logic [DW-1:0]      v1;
        logic               r2;
        logic [TAGW-1:0]    t2;
        logic [DW-1:0]      v2;
    } entry_t;

    entry_t           ent  [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [OCCW-1:0]  occ;

    entry_t           woke [DEPTH+1];
    logic [DEPTH:0]   wvld;
    entry_t           nent [DEPTH];
    logic [DEPTH-1:0] nvld;
    entry_t           dent;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] gnt;
    logic [IW-1:0]    sel_idx;
    logic             issue;
    logic             fire;
    logic             sh;
    logic [OCCW-1:0]  wpos;
    logic [OCCW-1:0]  occ_nxt;

    assign disp_ready = (occ < OCCW'(DEPTH));
    assign fire       = disp_valid && disp_ready;
    assign occupancy  = occ;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy[i] = vld[i] && ent[i].r1 && ent[i].r2;
        end
    end

    rs_select #(.N(DEPTH)) u_sel (
        .req (rdy),
        .gnt (gnt),
        .idx (sel_idx),
        .any (issue)
    );

    // A source not yet ready may be satisfied by the broadcast in the same cycle.
    always_comb begin
        dent       = '0;
        dent.alu   = disp_alusignals;
        dent.isimm = disp_isimmediate;
        dent.immx  = disp_immx;
        dent.dst   = disp_dst_tag;
        dent.t1    = disp_src1_tag;
        dent.t2    = disp_src2_tag;
        dent.r1    = disp_src1_rdy || (cdb_valid && disp_src1_tag == cdb_tag);
        dent.v1    = (!disp_src1_rdy && cdb_valid && disp_src1_tag == cdb_tag)
                     ? cdb_val : disp_src1_val;
        dent.r2    = disp_isimmediate || disp_src2_rdy
                     || (cdb_valid && disp_src2_tag == cdb_tag);
        dent.v2    = (!disp_isimmediate && !disp_src2_rdy && cdb_valid
                      && disp_src2_tag == cdb_tag) ? cdb_val : disp_src2_val;
    end

    // Wakeup is applied before the shift so a captured value moves with its entry.
    always_comb begin
        wvld         = '0;
        woke[DEPTH]  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woke[i] = ent[i];
            wvld[i] = vld[i];
            if (vld[i] && cdb_valid) begin
                if (!ent[i].r1 && ent[i].t1 == cdb_tag) begin
                    woke[i].r1 = 1'b1;
                    woke[i].v1 = cdb_val;
                end
                if (!ent[i].r2 && ent[i].t2 == cdb_tag) begin
                    woke[i].r2 = 1'b1;
                    woke[i].v2 = cdb_val;
                end
            end
        end
    end

    always_comb begin
        sh      = 1'b0;
        nvld    = '0;
        wpos    = occ - OCCW'(issue);
        occ_nxt = occ + OCCW'(fire) - OCCW'(issue);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sh = sh | gnt[i];
            if (issue && sh) begin
                nent[i] = woke[i+1];
                nvld[i] = wvld[i+1];
            end else begin
                nent[i] = woke[i];
                nvld[i] = wvld[i];
            end
            if (fire && OCCW'(i) == wpos) begin
                nent[i] = dent;
                nvld[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld             <= '0;
            occ             <= '0;
            iss_valid       <= 1'b0;
            iss_alusignals  <= '0;
            iss_op1         <= '0;
            iss_op2         <= '0;
            iss_immx        <= '0;
            iss_isimmediate <= 1'b0;
            iss_dst_tag     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            vld       <= '0;
            occ       <= '0;
            iss_valid <= 1'b0;
        end else begin
            vld       <= nvld;
            occ       <= occ_nxt;
            iss_valid <= issue;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent[i] <= nent[i];
            end
            if (issue) begin
                iss_alusignals  <= ent[sel_idx].alu;
                iss_op1         <= ent[sel_idx].v1;
                iss_op2         <= ent[sel_idx].v2;
                iss_immx        <= ent[sel_idx].immx;
                iss_isimmediate <= ent[sel_idx].isimm;
                iss_dst_tag     <= ent[sel_idx].dst;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed-vector bench for alu_rs: latency, wakeup, bypass, full/compaction, order, flush, reset.
module tb_alu_rs;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [11:0] disp_alusignals;
    logic        disp_isimmediate;
    logic [4:0]  disp_immx;
    logic        disp_src1_rdy;
    logic        disp_src2_rdy;
    logic [2:0]  disp_src1_tag;
    logic [2:0]  disp_src2_tag;
    logic [15:0] disp_src1_val;
    logic [15:0] disp_src2_val;
    logic [2:0]  disp_dst_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_val;
    logic        iss_valid;
    logic [11:0] iss_alusignals;
    logic [15:0] iss_op1;
    logic [15:0] iss_op2;
    logic [4:0]  iss_immx;
    logic        iss_isimmediate;
    logic [2:0]  iss_dst_tag;
    logic [2:0]  occupancy;

    int ncmp = 0;
    int nerr = 0;

    alu_rs #(.DEPTH(4), .TAGW(3), .DW(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .disp_valid       (disp_valid),
        .disp_ready       (disp_ready),
        .disp_alusignals  (disp_alusignals),
        .disp_isimmediate (disp_isimmediate),
        .disp_immx        (disp_immx),
        .disp_src1_rdy    (disp_src1_rdy),
        .disp_src2_rdy    (disp_src2_rdy),
        .disp_src1_tag    (disp_src1_tag),
        .disp_src2_tag    (disp_src2_tag),
        .disp_src1_val    (disp_src1_val),
        .disp_src2_val    (disp_src2_val),
        .disp_dst_tag     (disp_dst_tag),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_val          (cdb_val),
        .iss_valid        (iss_valid),
        .iss_alusignals   (iss_alusignals),
        .iss_op1          (iss_op1),
        .iss_op2          (iss_op2),
        .iss_immx         (iss_immx),
        .iss_isimmediate  (iss_isimmediate),
        .iss_dst_tag      (iss_dst_tag),
        .occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive(input logic [11:0] a, input logic imm, input logic [4:0] ix,
                         input logic r1, input logic [2:0] t1, input logic [15:0] v1,
                         input logic r2, input logic [2:0] t2, input logic [15:0] v2,
                         input logic [2:0] dst);
        disp_valid       = 1'b1;
        disp_alusignals  = a;
        disp_isimmediate = imm;
        disp_immx        = ix;
        disp_src1_rdy    = r1;
        disp_src1_tag    = t1;
        disp_src1_val    = v1;
        disp_src2_rdy    = r2;
        disp_src2_tag    = t2;
        disp_src2_val    = v2;
        disp_dst_tag     = dst;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_val   = v;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle();
        drive(12'h0, 1'b0, 5'h0, 1'b0, 3'h0, 16'h0, 1'b0, 3'h0, 16'h0, 3'h0);
        disp_valid = 1'b0;
        cdb_tag = 3'h0;
        cdb_val = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        ncmp++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        ncmp++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", disp_ready); end
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL reset_iss_valid got %b exp 0", iss_valid); end
        ncmp++; if (iss_op1 !== 16'h0) begin nerr++; $display("FAIL reset_op1 got %h exp 0000", iss_op1); end
        ncmp++; if (iss_alusignals !== 12'h0) begin nerr++; $display("FAIL reset_alu got %h exp 000", iss_alusignals); end
    endtask

    task automatic test_add_ready;
        drive(12'h001, 1'b0, 5'h0, 1'b1, 3'h0, 16'h0005, 1'b1, 3'h0, 16'h0003, 3'd2);
        tick();
        idle();
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL add_early got %b exp 0", iss_valid); end
        ncmp++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL add_occ1 got %0d exp 1", occupancy); end
        tick();
        ncmp++; if (iss_valid !== 1'b1) begin nerr++; $display("FAIL add_valid got %b exp 1", iss_valid); end
        ncmp++; if (iss_op1 !== 16'h0005) begin nerr++; $display("FAIL add_op1 got %h exp 0005", iss_op1); end
        ncmp++; if (iss_op2 !== 16'h0003) begin nerr++; $display("FAIL add_op2 got %h exp 0003", iss_op2); end
        ncmp++; if (iss_dst_tag !== 3'd2) begin nerr++; $display("FAIL add_dst got %0d exp 2", iss_dst_tag); end
        ncmp++; if (iss_alusignals !== 12'h001) begin nerr++; $display("FAIL add_alu got %h exp 001", iss_alusignals); end
        ncmp++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL add_occ0 got %0d exp 0", occupancy); end
        tick();
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL add_empty got %b exp 0", iss_valid); end
    endtask

    task automatic test_wakeup;
        drive(12'h002, 1'b0, 5'h0, 1'b0, 3'd4, 16'h0000, 1'b1, 3'h0, 16'h0007, 3'd3);
        tick();
        idle();
        tick();
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL wake_wait got %b exp 0", iss_valid); end
        ncmp++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL wake_occ got %0d exp 1", occupancy); end
        cdb(3'd4, 16'h0009);
        tick();
        idle();
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL wake_same got %b exp 0", iss_valid); end
        tick();
        ncmp++; if (iss_valid !== 1'b1) begin nerr++; $display("FAIL wake_valid got %b exp 1", iss_valid); end
        ncmp++; if (iss_op1 !== 16'h0009) begin nerr++; $display("FAIL wake_op1 got %h exp 0009", iss_op1); end
        ncmp++; if (iss_op2 !== 16'h0007) begin nerr++; $display("FAIL wake_op2 got %h exp 0007", iss_op2); end
        ncmp++; if (iss_alusignals !== 12'h002) begin nerr++; $display("FAIL wake_alu got %h exp 002", iss_alusignals); end
        ncmp++; if (iss_dst_tag !== 3'd3) begin nerr++; $display("FAIL wake_dst got %0d exp 3", iss_dst_tag); end
        tick();
    endtask

    task automatic test_bypass;
        drive(12'h001, 1'b0, 5'h0, 1'b0, 3'd6, 16'h1234, 1'b1, 3'h0, 16'h0001, 3'd5);
        cdb(3'd6, 16'h00AA);
        tick();
        idle();
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL byp_early got %b exp 0", iss_valid); end
        tick();
        ncmp++; if (iss_valid !== 1'b1) begin nerr++; $display("FAIL byp_valid got %b exp 1", iss_valid); end
        ncmp++; if (iss_op1 !== 16'h00AA) begin nerr++; $display("FAIL byp_op1 got %h exp 00aa", iss_op1); end
        ncmp++; if (iss_dst_tag !== 3'd5) begin nerr++; $display("FAIL byp_dst got %0d exp 5", iss_dst_tag); end
        tick();
    endtask

    task automatic test_full;
        for (int k = 0; k < 4; k++) begin
            drive(12'h001, 1'b0, 5'h0, 1'b0, 3'(k + 1), 16'h0, 1'b1, 3'h0, 16'(16'h0100 + k), 3'(k));
            tick();
        end
        drive(12'h001, 1'b0, 5'h0, 1'b0, 3'd5, 16'h0, 1'b1, 3'h0, 16'h0999, 3'd7);
        ncmp++; if (disp_ready !== 1'b0) begin nerr++; $display("FAIL full_ready got %b exp 0", disp_ready); end
        ncmp++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL full_occ got %0d exp 4", occupancy); end
        tick();
        ncmp++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL full_reject got %0d exp 4", occupancy); end
        idle();
        cdb(3'd3, 16'h0033);
        tick();
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL full_wake got %b exp 0", iss_valid); end
        ncmp++; if (disp_ready !== 1'b0) begin nerr++; $display("FAIL full_ready2 got %b exp 0", disp_ready); end
        cdb(3'd4, 16'h0044);
        tick();
        ncmp++; if (iss_valid !== 1'b1) begin nerr++; $display("FAIL full_iss got %b exp 1", iss_valid); end
        ncmp++; if (iss_dst_tag !== 3'd2) begin nerr++; $display("FAIL full_dst2 got %0d exp 2", iss_dst_tag); end
        ncmp++; if (iss_op1 !== 16'h0033) begin nerr++; $display("FAIL full_op1 got %h exp 0033", iss_op1); end
        ncmp++; if (iss_op2 !== 16'h0102) begin nerr++; $display("FAIL full_op2 got %h exp 0102", iss_op2); end
        ncmp++; if (occupancy !== 3'd3) begin nerr++; $display("FAIL full_occ3 got %0d exp 3", occupancy); end
        ncmp++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL full_ready3 got %b exp 1", disp_ready); end
        cdb(3'd1, 16'h0011);
        tick();
        ncmp++; if (iss_dst_tag !== 3'd3) begin nerr++; $display("FAIL shift_dst3 got %0d exp 3", iss_dst_tag); end
        ncmp++; if (iss_op1 !== 16'h0044) begin nerr++; $display("FAIL shift_op1 got %h exp 0044", iss_op1); end
        ncmp++; if (occupancy !== 3'd2) begin nerr++; $display("FAIL shift_occ got %0d exp 2", occupancy); end
        cdb(3'd2, 16'h0022);
        tick();
        ncmp++; if (iss_dst_tag !== 3'd0) begin nerr++; $display("FAIL drain_dst0 got %0d exp 0", iss_dst_tag); end
        ncmp++; if (iss_op1 !== 16'h0011) begin nerr++; $display("FAIL drain_op0 got %h exp 0011", iss_op1); end
        idle();
        tick();
        ncmp++; if (iss_dst_tag !== 3'd1) begin nerr++; $display("FAIL drain_dst1 got %0d exp 1", iss_dst_tag); end
        ncmp++; if (iss_op1 !== 16'h0022) begin nerr++; $display("FAIL drain_op1 got %h exp 0022", iss_op1); end
        ncmp++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL drain_occ got %0d exp 0", occupancy); end
        tick();
    endtask

    task automatic test_back_to_back;
        drive(12'h004, 1'b0, 5'h0, 1'b1, 3'h0, 16'h0006, 1'b1, 3'h0, 16'h0007, 3'd1);
        tick();
        drive(12'h080, 1'b1, 5'h05, 1'b1, 3'h0, 16'h00F0, 1'b0, 3'd7, 16'h000F, 3'd4);
        tick();
        idle();
        ncmp++; if (iss_alusignals !== 12'h004) begin nerr++; $display("FAIL b2b_mul got %h exp 004", iss_alusignals); end
        ncmp++; if (iss_dst_tag !== 3'd1) begin nerr++; $display("FAIL b2b_dst1 got %0d exp 1", iss_dst_tag); end
        ncmp++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL b2b_occ got %0d exp 1", occupancy); end
        tick();
        ncmp++; if (iss_valid !== 1'b1) begin nerr++; $display("FAIL b2b_valid got %b exp 1", iss_valid); end
        ncmp++; if (iss_alusignals !== 12'h080) begin nerr++; $display("FAIL b2b_or got %h exp 080", iss_alusignals); end
        ncmp++; if (iss_op1 !== 16'h00F0) begin nerr++; $display("FAIL imm_op1 got %h exp 00f0", iss_op1); end
        ncmp++; if (iss_op2 !== 16'h000F) begin nerr++; $display("FAIL imm_op2 got %h exp 000f", iss_op2); end
        ncmp++; if (iss_isimmediate !== 1'b1) begin nerr++; $display("FAIL imm_flag got %b exp 1", iss_isimmediate); end
        ncmp++; if (iss_immx !== 5'h05) begin nerr++; $display("FAIL imm_immx got %h exp 05", iss_immx); end
        ncmp++; if (iss_dst_tag !== 3'd4) begin nerr++; $display("FAIL b2b_dst4 got %0d exp 4", iss_dst_tag); end
        tick();
    endtask

    task automatic test_flush;
        drive(12'h001, 1'b0, 5'h0, 1'b0, 3'd5, 16'h0, 1'b1, 3'h0, 16'h0, 3'd0);
        tick();
        drive(12'h001, 1'b0, 5'h0, 1'b0, 3'd5, 16'h0, 1'b1, 3'h0, 16'h0, 3'd1);
        tick();
        drive(12'h001, 1'b0, 5'h0, 1'b1, 3'h0, 16'h0077, 1'b1, 3'h0, 16'h0, 3'd2);
        tick();
        idle();
        ncmp++; if (occupancy !== 3'd3) begin nerr++; $display("FAIL flush_pre got %0d exp 3", occupancy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ncmp++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid got %b exp 0", iss_valid); end
        ncmp++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL flush_ready got %b exp 1", disp_ready); end
        cdb(3'd5, 16'h0001);
        tick();
        idle();
        tick();
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL flush_gone got %b exp 0", iss_valid); end
    endtask

    task automatic test_async_reset;
        drive(12'h001, 1'b0, 5'h0, 1'b1, 3'h0, 16'h0055, 1'b1, 3'h0, 16'h0001, 3'd6);
        tick();
        drive(12'h001, 1'b0, 5'h0, 1'b0, 3'd2, 16'h0, 1'b1, 3'h0, 16'h0, 3'd7);
        tick();
        idle();
        ncmp++; if (iss_valid !== 1'b1) begin nerr++; $display("FAIL ar_pre_valid got %b exp 1", iss_valid); end
        ncmp++; if (occupancy !== 3'd1) begin nerr++; $display("FAIL ar_pre_occ got %0d exp 1", occupancy); end
        #2;
        rst = 1'b1;
        #1;
        ncmp++; if (iss_valid !== 1'b0) begin nerr++; $display("FAIL ar_valid got %b exp 0", iss_valid); end
        ncmp++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL ar_occ got %0d exp 0", occupancy); end
        ncmp++; if (iss_op1 !== 16'h0) begin nerr++; $display("FAIL ar_op1 got %h exp 0000", iss_op1); end
        ncmp++; if (iss_dst_tag !== 3'd0) begin nerr++; $display("FAIL ar_dst got %0d exp 0", iss_dst_tag); end
        ncmp++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL ar_ready got %b exp 1", disp_ready); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add_ready();
        test_wakeup();
        test_bypass();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

Four-entry ALU reservation station placed directly upstream of the `alu` execution unit. It accepts decoded ALU ops from dispatch. Each entry waits until its source operands are available, capturing them from the common data bus (CDB) broadcast. The block then issues the oldest ready op, as registered operands, to the ALU inputs (`alusignals`, `op1`, `op2`, `immx`, `isimmediate`). It also tags each op so the downstream result can be written back.

## Interface
- `DEPTH`, 4: number of entries (2..8).
- `TAGW`, 3: width of a rename/ROB tag.
- `DW`, 16: data width, matching the ALU operand width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discards all entries and any pending issue.
- `disp_valid`  in  1  dispatch offers an op.
- `disp_ready`  out  1  station can accept (not full).
- `disp_alusignals`  in  12  one-hot ALU op (bit0 add … bit11 lsr).
- `disp_isimmediate`  in  1  op2 is replaced by `immx` in the ALU.
- `disp_immx`  in  5  immediate.
- `disp_src1_rdy`, `disp_src2_rdy`  in  1 each  operand value already valid.
- `disp_src1_tag`, `disp_src2_tag`  in  TAGW each  producer tag when not ready.
- `disp_src1_val`, `disp_src2_val`  in  DW each  operand value when ready.
- `disp_dst_tag`  in  TAGW  tag of this op's result.
- `cdb_valid`  in  1  result broadcast this cycle.
- `cdb_tag`  in  TAGW  broadcast tag.
- `cdb_val`  in  DW  broadcast value.
- `iss_valid`  out  1  registered: issue fields hold an op this cycle.
- `iss_alusignals`  out  12  to ALU `alusignals`.
- `iss_op1`, `iss_op2`  out  DW each  to ALU `op1`/`op2`.
- `iss_immx`  out  5  to ALU `immx`.
- `iss_isimmediate`  out  1  to ALU `isimmediate`.
- `iss_dst_tag`  out  TAGW  travels with the result.
- `occupancy`  out  clog2(DEPTH+1)  valid entry count.

## Operation
- Entry fields: valid, alusignals, isimmediate, immx, dst_tag, and per source a rdy/tag/val triple.
- The queue is age-ordered and compacting: index 0 is the oldest entry. A new entry is written at index `occupancy`.
- Dispatch handshake: the transfer happens on an edge with `disp_valid && disp_ready`. `disp_ready = (occupancy < DEPTH)`, computed from registered state only. An issue in the same cycle does not free a slot for that cycle.
- Source readiness for an op with `isimmediate=1`:
  - src2 counts as ready at dispatch, whatever `disp_src2_rdy` says.
  - The stored src2 value is `disp_src2_val`.
- Wakeup: on `cdb_valid`, every valid entry with a source where `!rdy && tag==cdb_tag` captures `cdb_val` and sets rdy.
- Dispatch-time bypass: if a dispatching source is not ready and its tag equals `cdb_tag` while `cdb_valid`, that source is written as ready with `cdb_val`.
- Select: the lowest-index entry with valid, src1 rdy and src2 rdy. Selection uses registered state only, so an entry woken or written on edge N is selectable from cycle N+1.
- Issue: at most one op per cycle.
  - On each edge, the iss_* registers load the selected entry and `iss_valid=1`.
  - If no entry is selected, `iss_valid=0` and the remaining iss_* fields hold their previous values.
  - The selected entry is removed, and higher entries shift down by one.
- Simultaneous dispatch and issue: the new entry is written at `occupancy-1` after the shift. Occupancy is unchanged.
- Simultaneous wakeup and shift: a captured CDB value follows the entry to its new index.
- `flush`: on the edge, all entries are invalidated and `iss_valid` goes to 0. Flush overrides dispatch and issue in that cycle. `disp_ready` is 1 the following cycle.
- Reset values: all entries invalid, `occupancy=0`, `iss_valid=0`, all iss_* fields 0, `disp_ready=1`.

## Timing
- Minimum latency for an op dispatched with both sources ready:
  - Written on edge N.
  - Selected during cycle N+1.
  - `iss_valid=1` after edge N+1.
- Wakeup to issue: a CDB match on edge N leads to `iss_valid` after edge N+1 at the earliest.
- Throughput: one issue per cycle. The ALU always accepts, so there is no issue back-pressure.
- Full boundary: with `occupancy==DEPTH`, `disp_ready=0`, even if an issue occurs in that cycle.
- Empty boundary: `iss_valid=0` every cycle while no entry is ready.
- Asynchronous reset mid-operation clears all state immediately, without waiting for a clock edge.

## Structure
- Shared package `alu_pkg`:
  - ALU op bit indices (ADD=0 … LSR=11) and `ALU_OPW=12`.
  - `DW=16` and `IMMW=5`.
  - The tag width default.
- Sub-module `rs_select`: a combinational oldest-ready priority picker. It takes the per-entry ready vector and outputs a one-hot grant and an index.

## Test plan
- Reset, then dispatch ADD (alusignals=12'h001) with src1=5 and src2=3, both ready, dst=2 → after 2 edges, `iss_valid=1`, `iss_op1=5`, `iss_op2=3`, `iss_dst_tag=2`.
- Dispatch SUB with src1 waiting on tag 4, then CDB tag=4 val=16'h0009 → the op issues the cycle after the broadcast with `iss_op1=9`.
- Dispatch an op whose src1 tag=6 is not ready while CDB broadcasts tag 6 val=16'h00AA in the same cycle → bypass, and the op issues with `iss_op1=16'h00AA` after 2 edges.
- Fill 4 entries that are not ready → `disp_ready=0` and `occupancy=4`. Wake entry 2 → it issues first, the others shift, and `disp_ready` returns to 1.
- Two ready entries (MUL older, OR younger) → MUL issues first and OR the next cycle.
- Assert `flush` with 3 entries and a pending issue → the next cycle shows `occupancy=0`, `iss_valid=0`, `disp_ready=1`. Asynchronous `rst` mid-stream also zeroes all outputs immediately.
